// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority vote on samples 7..9,
// start-glitch rejection and framing-error detection with break hold-off.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       rx_down,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_rx_s;
  logic [DW-1:0] r_div;
  logic [3:0]  r_samp;
  logic [1:0]  r_vote;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_po;
  logic        r_rx_down;
  logic        r_frame_err;

  logic        w_tick;
  logic        w_decide;
  logic        w_wrap;
  logic        w_majority;
  logic        w_load;
  logic        w_ferr;
  logic        w_shift_en;

  assign w_tick     = (r_state != S_IDLE) && (r_div == DW'(DIV - 1));
  assign w_decide   = w_tick && (r_samp == 4'd9);
  assign w_wrap     = w_tick && (r_samp == 4'd15);
  // r_vote holds samples 7 and 8; sample 9 is the live synchronized input.
  assign w_majority = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_rx_s) | (r_vote[1] & r_rx_s);

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_ferr     = 1'b0;
    w_shift_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_next = S_START;
      end
      S_START: begin
        if (w_decide && w_majority) w_next = S_IDLE;
        else if (w_wrap)            w_next = S_DATA;
      end
      S_DATA: begin
        if (w_decide) w_shift_en = 1'b1;
        if (w_wrap && (r_bit_idx == 3'd7)) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_decide) begin
          if (w_majority) begin
            w_load = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_div       <= '0;
      r_samp      <= '0;
      r_vote      <= '1;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_po        <= '0;
      r_rx_down   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_rx_s      <= r_sync1;
      r_state     <= w_next;
      r_rx_down   <= w_load;
      r_frame_err <= w_ferr;
      if (w_load) r_po <= r_shift;
      if (w_shift_en) r_shift <= {w_majority, r_shift[7:1]};

      // Counters sit at zero while idle, so the first START cycle is sample 0.
      if (r_state == S_IDLE) begin
        r_div     <= '0;
        r_samp    <= '0;
        r_bit_idx <= '0;
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          r_samp <= r_samp + 4'd1;
          if (r_samp == 4'd7) r_vote[0] <= r_rx_s;
          if (r_samp == 4'd8) r_vote[1] <= r_rx_s;
          if ((r_state == S_DATA) && (r_samp == 4'd15)) r_bit_idx <= r_bit_idx + 3'd1;
        end
      end
    end
  end

  assign po_data   = r_po;
  assign rx_down   = r_rx_down;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at DIV = 1 (16 clocks per bit); a frame-level
// expectation queue plus a per-cycle compare process check every strobe and po_data.
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] po_data;
  logic       rx_down;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_byte_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .po_data(po_data),
    .rx_down(rx_down), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    bit          ferr;
    logic [7:0]  data;
    int unsigned early;
    int unsigned late;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model_po = 8'h00;
  int          rxd_cnt = 0;
  int          ferr_cnt = 0;
  int unsigned last_rxd_cyc = 0;
  int          gap_cnt = 0;
  int          last_gap = 99;
  bit          gap_meas = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_range(input string nm, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d (cycle %0d)", nm, v, lo, hi, cyc);
    end
  endtask

  // A received frame must strobe 155..158 clocks after its start edge is driven.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input bit spike,
                            input bit expect_ev, input int rst_bit, output int unsigned t0);
    logic [9:0] bits;
    exp_t       e;
    bits = {stopv, d, 1'b0};
    t0   = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) begin
          t0 = cyc;
          if (expect_ev) begin
            e.ferr  = !stopv;
            e.data  = d;
            e.early = cyc + 155;
            e.late  = cyc + 158;
            q.push_back(e);
          end
        end
        rx  = bits[i] ^ ((spike && i >= 1 && i <= 8 && c == 8) ? 1'b1 : 1'b0);
        rst = (i == rst_bit && c == 8);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : compare
    bit   rst_e;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      rst_e = rst;
      #1;
      if (rst_e) model_po = 8'h00;
      chk("strobe_excl", {31'b0, rx_down & frame_err}, 32'd0);
      if (rx_down || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {30'b0, rx_down, frame_err}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", {31'b0, frame_err}, {31'b0, e.ferr});
          chk_range("strobe_cycle", int'(cyc), int'(e.early), int'(e.late));
          if (!e.ferr) model_po = e.data;
        end
      end
      while (q.size() > 0 && cyc > q[0].late) begin
        chk("missed_strobe", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      chk("po_data", {24'b0, po_data}, {24'b0, model_po});
      if (rx_down) begin
        rxd_cnt++;
        last_rxd_cyc = cyc;
        gap_meas = 1'b1;
        gap_cnt  = 1;
      end else if (gap_meas) begin
        if (busy) begin
          last_gap = gap_cnt;
          gap_meas = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin : stim
    int unsigned t0;
    int          base_r;
    int          base_f;
    int          n;
    rx  = 1'b1;
    rst = 1'b1;
    idle(5);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_po_data", {24'b0, po_data}, 32'h00);
    chk("reset_rx_down", {31'b0, rx_down}, 32'd0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    idle(10);

    // Two back-to-back command bytes
    base_r = rxd_cnt;
    send_frame(8'h51, 1'b1, 1'b0, 1'b1, -1, t0);
    chk("byte_Q", {24'b0, po_data}, 32'h51);
    send_frame(8'h31, 1'b1, 1'b0, 1'b1, -1, t0);
    idle(20);
    chk("two_bytes_count", rxd_cnt - base_r, 32'd2);
    chk("byte_1", {24'b0, po_data}, 32'h31);
    chk_range("idle_gap", last_gap, 1, 8);
    chk("no_ferr_yet", ferr_cnt, 32'd0);

    // Start glitch
    base_r = rxd_cnt;
    @(negedge clk); rx = 1'b0;
    idle(4);
    chk("glitch_busy_high", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
    chk_range("glitch_busy_fall", n, 1, 12);
    idle(30);
    chk("glitch_no_rx_down", rxd_cnt - base_r, 32'd0);
    chk("glitch_no_ferr", ferr_cnt, 32'd0);
    chk("glitch_po_data", {24'b0, po_data}, 32'h31);

    // Framing error followed by a held-low break
    base_r = rxd_cnt;
    base_f = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(40);
    chk("break_busy_high", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
    chk_range("break_busy_fall", n, 1, 3);
    chk("ferr_once", ferr_cnt - base_f, 32'd1);
    chk("ferr_no_rx_down", rxd_cnt - base_r, 32'd0);
    chk("ferr_po_kept", {24'b0, po_data}, 32'h31);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, t0);
    idle(20);
    chk("after_ferr_byte", {24'b0, po_data}, 32'h3C);

    // Mid-bit noise spikes rejected by majority vote
    base_r = rxd_cnt;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, -1, t0);
    idle(20);
    chk("noise_byte", {24'b0, po_data}, 32'h0F);
    chk("noise_count", rxd_cnt - base_r, 32'd1);

    // Reset during data bit 4 aborts the frame and clears po_data
    base_r = rxd_cnt;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 5, t0);
    idle(20);
    chk("abort_no_rx_down", rxd_cnt - base_r, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_po_cleared", {24'b0, po_data}, 32'h00);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, -1, t0);
    idle(20);
    chk("after_abort_byte", {24'b0, po_data}, 32'h81);
    chk("after_abort_count", rxd_cnt - base_r, 32'd1);

    // Latency from start edge to strobe
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, -1, t0);
    idle(20);
    chk_range("latency", int'(last_rxd_cyc - t0), 155, 158);
    chk("latency_byte", {24'b0, po_data}, 32'h00);

    idle(200);
    chk("queue_empty", q.size(), 32'd0);
    chk("total_ferr", ferr_cnt, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout required completion (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Receives 8N1 asynchronous serial bytes from the voice-recognition module's TX line and presents each good byte as `po_data` with a single-cycle `rx_down` strobe. It sits directly upstream of the voice-command decoders, which shift these bytes into a command register and match instruction strings such as "Q1". It uses 16x oversampling, majority-vote sampling, start-bit glitch rejection and framing-error detection.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `DIV` (localparam) = CLK_FREQ / (BAUD*16), truncated. Must be ≥ 1.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `po_data`  out  8  last correctly received byte.
- `rx_down`  out  1  one-cycle strobe: `po_data` was updated this cycle.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low; byte discarded.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Input synchronizer.** `rx` passes through a 2-FF synchronizer, giving `rx_s`. Both flops reset to 1.
- **Tick generator.** The divider counter runs 0..DIV-1 and emits `tick` when it reaches DIV-1. It is cleared on entry to START, so sampling phase is aligned to the detected edge.
- **Sample counter.** A 4-bit counter (0..15) increments on each `tick` and wraps 15→0 at the bit boundary. It is cleared on entry to START.
- **Majority vote.** Samples 7, 8 and 9 of each bit are latched. The bit value is the majority of the three, decided on the tick at sample 9.
- **START state.**
  - Entered from IDLE when `rx_s == 0`.
  - At sample 9: majority 0 → continue; majority 1 → glitch, return to IDLE with no outputs.
  - At the wrap after sample 15 → DATA, bit index = 0.
- **DATA state.**
  - 8 bits, LSB first. Each decided bit is shifted into bit 7 of the shift register, so after 8 bits it holds the byte in natural order.
  - After the wrap of bit 7 → STOP.
- **STOP state.**
  - At sample 9, majority 1: load `po_data` from the shift register, pulse `rx_down`, go to IDLE immediately. The remainder of the stop bit is not waited out, so back-to-back frames are accepted.
  - At sample 9, majority 0: pulse `frame_err`, leave `po_data` unchanged, go to BREAK.
- **BREAK state.** Wait until `rx_s == 1`, then go to IDLE. A held-low (break) line produces exactly one `frame_err` and no further frames.
- **Reset.** `rst` mid-frame discards the partial byte and forces IDLE with all counters cleared. No `rx_down` or `frame_err` is issued for an aborted frame.

## Timing
- Reset values:
  - `po_data` = 0x00; `rx_down` = 0; `frame_err` = 0; `busy` = 0.
  - State = IDLE; sync flops = 1.
- `rx_down` and `frame_err` are registered, high for exactly one `clk` cycle, and mutually exclusive.
- `po_data` changes only in the cycle `rx_down` is high. It holds its value otherwise, including across frame errors.
- `busy` rises one cycle after IDLE→START; it falls in the cycle `rx_down` is high, or when BREAK/glitch returns to IDLE.
- Latency: from the `rx` falling edge to `rx_down` is 2–3 cycles of synchronizer delay plus (9*16 + 9 + 1) ticks of DIV clocks. With DIV = 1, `rx_down` occurs 155–158 cycles after the edge.
- Bit period is 16*DIV clocks. Truncation error in DIV must stay under 2% of the bit period. At the defaults, DIV = 325: 5200 clocks per bit, −0.16% error.
- `rx` transitions are tolerated at any phase relative to `clk`. Simultaneous `rst` and a decision tick: `rst` wins.

## Test plan
All directed tests use CLK_FREQ = 1_600_000 and BAUD = 100_000, so DIV = 1 and one bit = 16 clocks.
- **Two command bytes.** Send 0x51 ('Q') then 0x31 ('1') back-to-back with a 1-bit stop. Required: two `rx_down` pulses with `po_data` = 0x51 then 0x31; `frame_err` never high; `busy` low between frames for ≤ 8 cycles.
- **Start glitch.** Drive `rx` low for 4 clocks, then high. Required: `busy` pulses, returns to 0 within 12 cycles; no `rx_down`, no `frame_err`; `po_data` unchanged.
- **Framing error.** Send 0xA5 with the stop bit low, then hold `rx` low for 40 further clocks, then release high. Required: exactly one `frame_err`; no `rx_down`; `po_data` keeps its prior value; `busy` falls ≤ 3 cycles after the release. A following 0x3C is then received correctly.
- **Mid-bit noise.** Send 0x0F with a 1-clock inverted spike at sample 8 of every data bit. Required: `po_data` = 0x0F and `rx_down` pulses once (majority vote rejects the spikes).
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4 of 0xFF, then send 0x81. Required: no strobe for the aborted frame; `rx_down` once with `po_data` = 0x81.
- **Latency check.** Send 0x00. Measure the falling edge of `rx` → `rx_down`. Required: 155–158 cycles.
